// File: rtl/gol_window_gen.sv
// Game of Life window generator: turns a raster stream of cells into per-cell
// 3x3 neighbourhoods (a..h plus centre) using a 2*WIDTH+3 cell shift history.
module gol_window_gen #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_cell,
    output logic out_valid,
    input  logic out_ready,
    output logic out_a,
    output logic out_b,
    output logic out_c,
    output logic out_d,
    output logic out_e,
    output logic out_f,
    output logic out_g,
    output logic out_h,
    output logic out_centre,
    output logic out_last
);

    localparam int HL     = 2 * WIDTH + 3;
    localparam int NCELLS = WIDTH * HEIGHT;
    localparam int IW     = $clog2(NCELLS);
    localparam int CW     = $clog2(WIDTH);
    localparam int RW     = $clog2(HEIGHT);

    localparam logic [IW-1:0] FILL_LAST = IW'(WIDTH + 1);
    localparam logic [IW-1:0] IN_LAST   = IW'(NCELLS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            rst_done_r;
    logic [HL-1:0]   hist_r;
    logic [HL-1:0]   hist_next_s;
    logic [IW-1:0]   in_idx_r;
    logic [CW-1:0]   ld_col_r;
    logic [RW-1:0]   ld_row_r;
    logic            out_valid_r;
    logic            out_last_r;
    logic [8:0]      win_r;
    logic [8:0]      win_s;

    logic            in_ready_s;
    logic            accept_s;
    logic            slot_free_s;
    logic            load_s;
    logic            shift_s;
    logic            shift_bit_s;
    logic            frame_done_s;
    logic            at_last_s;

    // With cell k newest at h[0], cell k-j sits at h[j]; k is (r+1)*WIDTH+c+1.
    // Returns {a,b,c,d,e,f,g,h,centre} with off-grid neighbours forced dead.
    function automatic logic [8:0] pick_window(input logic [HL-1:0] h,
                                               input logic [RW-1:0] row,
                                               input logic [CW-1:0] col);
        logic top, bot, lft, rgt;
        top = (row == {RW{1'b0}});
        bot = (row == ROW_LAST);
        lft = (col == {CW{1'b0}});
        rgt = (col == COL_LAST);
        pick_window = {
            h[2*WIDTH+2] & ~top & ~lft,
            h[2*WIDTH+1] & ~top,
            h[2*WIDTH]   & ~top & ~rgt,
            h[WIDTH+2]   & ~lft,
            h[WIDTH]     & ~rgt,
            h[2]         & ~bot & ~lft,
            h[1]         & ~bot,
            h[0]         & ~bot & ~rgt,
            h[WIDTH+1]
        };
    endfunction

    // State register and post-reset enable for in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FILL;
            rst_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            rst_done_r <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (load_s) begin
                    state_s = (in_idx_r == IN_LAST) ? ST_FLUSH : ST_RUN;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (accept_s && (in_idx_r == IN_LAST)) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (frame_done_s) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: state_s = ST_FILL;
        endcase
    end

    // Per-state handshake and history/window control strobes.
    always_comb begin
        slot_free_s  = !out_valid_r || out_ready;
        in_ready_s   = 1'b0;
        shift_s      = 1'b0;
        shift_bit_s  = 1'b0;
        load_s       = 1'b0;
        frame_done_s = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            ST_FILL: begin
                in_ready_s  = rst_done_r;
                accept_s    = in_valid && in_ready_s;
                shift_s     = accept_s;
                shift_bit_s = in_cell;
                load_s      = accept_s && (in_idx_r == FILL_LAST);
            end
            ST_RUN: begin
                in_ready_s  = rst_done_r && slot_free_s;
                accept_s    = in_valid && in_ready_s;
                shift_s     = accept_s;
                shift_bit_s = in_cell;
                load_s      = accept_s;
            end
            ST_FLUSH: begin
                // Trailing windows are pushed out by shifting dead cells in.
                frame_done_s = out_valid_r && out_ready && out_last_r;
                load_s       = slot_free_s && !frame_done_s;
                shift_s      = load_s;
                shift_bit_s  = 1'b0;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    // Window is taken from the history as it will be after this cycle's shift.
    always_comb begin
        if (shift_s) begin
            hist_next_s = {hist_r[HL-2:0], shift_bit_s};
        end else begin
            hist_next_s = hist_r;
        end
        win_s     = pick_window(hist_next_s, ld_row_r, ld_col_r);
        at_last_s = (ld_row_r == ROW_LAST) && (ld_col_r == COL_LAST);
    end

    // History, input index and load-position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r   <= {HL{1'b0}};
            in_idx_r <= {IW{1'b0}};
            ld_col_r <= {CW{1'b0}};
            ld_row_r <= {RW{1'b0}};
        end else begin
            hist_r <= hist_next_s;
            if (frame_done_s) begin
                in_idx_r <= {IW{1'b0}};
            end else if (accept_s) begin
                in_idx_r <= (in_idx_r == IN_LAST) ? {IW{1'b0}} : in_idx_r + IW'(1);
            end
            if (frame_done_s) begin
                ld_col_r <= {CW{1'b0}};
                ld_row_r <= {RW{1'b0}};
            end else if (load_s) begin
                if (ld_col_r == COL_LAST) begin
                    ld_col_r <= {CW{1'b0}};
                    ld_row_r <= (ld_row_r == ROW_LAST) ? {RW{1'b0}} : ld_row_r + RW'(1);
                end else begin
                    ld_col_r <= ld_col_r + CW'(1);
                end
            end
        end
    end

    // Registered output window; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            win_r       <= 9'd0;
        end else begin
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= at_last_s;
                win_r       <= win_s;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign {out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h, out_centre} = win_r;

endmodule
